// File: rtl/raisin64_pkg.sv
// Shared definitions for the Raisin64 core: instruction encodings, field
// positions, datapath constants and the decoded-instruction record.
package raisin64_pkg;

   localparam int XLEN   = 64;
   localparam int NREGS  = 64;
   localparam int REG_AW = 6;

   // Instruction word field positions (LSB of each field)
   localparam int CLS_LSB  = 60;
   localparam int FUNC_LSB = 56;
   localparam int RD_LSB   = 50;
   localparam int RS1_LSB  = 44;
   localparam int RS2_LSB  = 38;
   localparam int IMM_LSB  = 0;

   typedef enum logic [3:0] {
      CLS_ALU  = 4'd0,
      CLS_ALUI = 4'd1,
      CLS_JMP  = 4'd2,
      CLS_BEQZ = 4'd3,
      CLS_JR   = 4'd4
   } cls_e;

   typedef enum logic [3:0] {
      FN_ADD = 4'd0,
      FN_SUB = 4'd1,
      FN_AND = 4'd2,
      FN_OR  = 4'd3,
      FN_XOR = 4'd4,
      FN_SLL = 4'd5,
      FN_SRL = 4'd6,
      FN_SRA = 4'd7,
      FN_SLT = 4'd8
   } func_e;

   typedef struct packed {
      logic [3:0]        cls;
      logic [3:0]        func;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   imm;
   } decoded_t;

   // Splits a raw word into fields; bits [37:32] carry no meaning.
   function automatic decoded_t decode(input logic [XLEN-1:0] word);
      decoded_t d;
      logic     unused_bits;
      d.cls       = word[CLS_LSB +: 4];
      d.func      = word[FUNC_LSB +: 4];
      d.rd        = word[RD_LSB +: REG_AW];
      d.rs1       = word[RS1_LSB +: REG_AW];
      d.rs2       = word[RS2_LSB +: REG_AW];
      d.imm       = {{32{word[IMM_LSB + 31]}}, word[IMM_LSB +: 32]};
      unused_bits = ^word[37:32];
      return d;
   endfunction

endpackage

// File: rtl/raisin64_alu.sv
// Raisin64 integer ALU: purely combinational, result = op1 <func> op2.
module raisin64_alu
   import raisin64_pkg::*;
(
   input  logic [3:0]  func,
   input  logic [63:0] op1,
   input  logic [63:0] op2,
   output logic [63:0] result
);

   logic [5:0] shamt;

   assign shamt = op2[5:0];

   // NOTE: every output of an always_comb block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      result = '0;
      case (func)
         FN_ADD:  result = op1 + op2;
         FN_SUB:  result = op1 - op2;
         FN_AND:  result = op1 & op2;
         FN_OR:   result = op1 | op2;
         FN_XOR:  result = op1 ^ op2;
         FN_SLL:  result = op1 << shamt;
         FN_SRL:  result = op1 >> shamt;
         FN_SRA:  result = $signed(op1) >>> shamt;
         FN_SLT:  result = {63'd0, $signed(op1) < $signed(op2)};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/raisin64_pipeline.sv
// Raisin64 three-stage pipeline (fetch, decode/execute, writeback) with inline
// register file. Define RAISIN64_TRACE_EN for a simulation writeback trace.
module raisin64_pipeline
   import raisin64_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   output logic        imem_addr_valid,
   input  logic [63:0] imem_data,
   input  logic        imem_data_valid
);

   logic [XLEN-1:0]   pc;
   logic              fetch_en;

   // IF/EX register
   logic              ifex_valid;
   logic [XLEN-1:0]   ifex_pc;
   decoded_t          ifex_insn;

   // Execute stage
   logic [XLEN-1:0]   rs1_val;
   logic [XLEN-1:0]   rs2_val;
   logic [XLEN-1:0]   alu_op2;
   logic [XLEN-1:0]   alu_result;
   logic              ex_we;
   logic              redirect;
   logic [XLEN-1:0]   redirect_pc;

   // WB register
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;

   logic [XLEN-1:0]   regs [NREGS];

   assign imem_addr = pc;
   assign fetch_en  = imem_addr_valid & imem_data_valid;

   // Operand read: R0 is hardwired, the WB result overrides the stale file entry
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (ifex_insn.rs1 != '0) begin
         rs1_val = (wb_we && wb_rd == ifex_insn.rs1) ? wb_data : regs[ifex_insn.rs1];
      end
      if (ifex_insn.rs2 != '0) begin
         rs2_val = (wb_we && wb_rd == ifex_insn.rs2) ? wb_data : regs[ifex_insn.rs2];
      end
   end

   assign alu_op2 = (ifex_insn.cls == CLS_ALUI) ? ifex_insn.imm : rs2_val;

   raisin64_alu u_alu (
      .func   (ifex_insn.func),
      .op1    (rs1_val),
      .op2    (alu_op2),
      .result (alu_result)
   );

   always_comb begin
      ex_we       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      if (ifex_valid) begin
         case (ifex_insn.cls)
            CLS_ALU, CLS_ALUI: ex_we = (ifex_insn.rd != '0);
            CLS_JMP: begin
               redirect    = 1'b1;
               redirect_pc = ifex_insn.imm << 3;
            end
            CLS_BEQZ: begin
               redirect    = (rs1_val == '0);
               redirect_pc = ifex_pc + (ifex_insn.imm << 3);
            end
            CLS_JR: begin
               redirect    = 1'b1;
               redirect_pc = {rs1_val[XLEN-1:3], 3'b000};
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc              <= '0;
         imem_addr_valid <= 1'b0;
         ifex_valid      <= 1'b0;
         wb_we           <= 1'b0;
      end else begin
         imem_addr_valid <= 1'b1;
         if (redirect) begin
            pc <= redirect_pc;
         end else if (fetch_en) begin
            pc <= pc + 64'd8;
         end
         // The word fetched alongside a taken transfer is squashed here
         ifex_valid <= fetch_en & ~redirect;
         wb_we      <= ex_we;
      end
   end

   // NOTE: payload registers are qualified by the valid bits above, so they
   // need no reset; only control state returns to a known value.
   always_ff @(posedge clk) begin
      if (fetch_en) begin
         ifex_insn <= decode(imem_data);
         ifex_pc   <= pc;
      end
      wb_rd   <= ifex_insn.rd;
      wb_data <= alu_result;
   end

   // NOTE: the register file must read as zero after reset, so this memory is
   // deliberately built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_we) begin
         regs[wb_rd] <= wb_data;
      end
   end

`ifdef RAISIN64_TRACE_EN
   logic            wb_valid;
   logic [XLEN-1:0] wb_pc;
   logic [XLEN-1:0] ifex_word;
   logic [XLEN-1:0] wb_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
      end else begin
         wb_valid <= ifex_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (fetch_en) begin
         ifex_word <= imem_data;
      end
      wb_pc   <= ifex_pc;
      wb_word <= ifex_word;
   end

   always @(posedge clk) begin
      if (rst_n && wb_valid) begin
         $display("[raisin64] pc=%h word=%h rd=%0d data=%h", wb_pc, wb_word, wb_rd,
                  wb_we ? wb_data : 64'd0);
      end
   end
`endif

endmodule

// File: tb/tb_raisin64_pipeline.sv
// Self-checking bench for raisin64_pipeline: directed scenarios plus random
// programs compared against an instruction-level model of the fetch stream.
module tb_raisin64_pipeline;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] imem_addr;
   logic        imem_addr_valid;
   logic [63:0] imem_data;
   logic        imem_data_valid;

   logic [63:0] rom   [64];
   logic [63:0] mregs [64];
   int          n_cmp = 0;
   int          n_bad = 0;

   raisin64_pipeline dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_addr_valid (imem_addr_valid),
      .imem_data       (imem_data),
      .imem_data_valid (imem_data_valid)
   );

   always #5 clk = ~clk;

   // Combinational instruction ROM; address aliases every 512 bytes
   assign imem_data = rom[imem_addr[8:3]];

   function automatic logic [63:0] enc(input int cls, input int fn, input int rd,
                                       input int rs1, input int rs2, input logic [31:0] imm);
      logic [63:0] w;
      w = '0;
      w[63:60] = cls[3:0];
      w[59:56] = fn[3:0];
      w[55:50] = rd[5:0];
      w[49:44] = rs1[5:0];
      w[43:38] = rs2[5:0];
      w[31:0]  = imm;
      return w;
   endfunction

   function automatic logic [63:0] ref_alu(input int fn, input logic [63:0] a, input logic [63:0] b);
      int          sh;
      logic [63:0] r;
      sh = int'(b % 64);
      case (fn)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a << sh;
         6: r = a >> sh;
         7: r = $signed(a) >>> sh;
         8: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // Architectural effect of one instruction; register writes land immediately
   task automatic ref_exec(input logic [63:0] w, input logic [63:0] ipc,
                           output logic taken, output logic [63:0] tgt);
      int          cls;
      int          fn;
      int          rd;
      logic [63:0] imm;
      logic [63:0] a;
      logic [63:0] b;
      cls   = int'(w[63:60]);
      fn    = int'(w[59:56]);
      rd    = int'(w[55:50]);
      imm   = {{32{w[31]}}, w[31:0]};
      a     = mregs[w[49:44]];
      b     = mregs[w[43:38]];
      taken = 1'b0;
      tgt   = 64'd0;
      case (cls)
         0, 1: begin
            if (cls == 1) b = imm;
            if (rd != 0) mregs[rd] = ref_alu(fn, a, b);
         end
         2: begin
            taken = 1'b1;
            tgt   = imm * 8;
         end
         3: begin
            if (a == 64'd0) begin
               taken = 1'b1;
               tgt   = ipc + imm * 8;
            end
         end
         4: begin
            taken = 1'b1;
            tgt   = a - (a % 8);
         end
         default: ;
      endcase
   endtask

   function automatic logic [63:0] rand_insn();
      int pick;
      int cls;
      pick = $urandom_range(0, 9);
      if (pick < 4)       cls = 0;
      else if (pick < 6)  cls = 1;
      else if (pick == 6) cls = 2;
      else if (pick == 7) cls = 3;
      else if (pick == 8) cls = 4;
      else                cls = $urandom_range(5, 15);
      return enc(cls, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom());
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 64'd0;
   endtask

   // Leaves the bench just after the first clock edge following release
   task automatic do_reset();
      imem_data_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      clear_rom();
      imem_data_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (imem_addr !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_addr: got %h want %h", imem_addr, 64'd0);
      end
      n_cmp++;
      if (imem_addr_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid: got %b want 0", imem_addr_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (imem_addr_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL valid_before_edge: got %b want 0", imem_addr_valid);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (imem_addr_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL valid_after_edge: got %b want 1", imem_addr_valid);
      end
      n_cmp++;
      if (imem_addr !== 64'd0) begin
         n_bad++;
         $display("FAIL first_addr: got %h want %h", imem_addr, 64'd0);
      end
   endtask

   task automatic test_nop_stream();
      logic [63:0] want;
      clear_rom();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         want = 64'(i * 8);
         n_cmp++;
         if (imem_addr !== want || imem_addr_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL nop_stream[%0d]: got %h/%b want %h/1", i, imem_addr, imem_addr_valid, want);
         end
      end
   endtask

   task automatic test_jmp();
      logic [63:0] want [4];
      clear_rom();
      rom[0] = enc(2, 0, 0, 0, 0, 32'h20);
      want   = '{64'h0, 64'h8, 64'h100, 64'h108};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_addr !== want[i]) begin
            n_bad++;
            $display("FAIL jmp[%0d]: got %h want %h", i, imem_addr, want[i]);
         end
      end
   endtask

   task automatic test_bypass();
      logic [63:0] want [5];
      clear_rom();
      rom[0] = enc(1, 0, 1, 0, 0, 32'h40);
      rom[1] = enc(4, 0, 0, 1, 0, 32'h0);
      want   = '{64'h0, 64'h8, 64'h10, 64'h40, 64'h48};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_addr !== want[i]) begin
            n_bad++;
            $display("FAIL bypass_jr[%0d]: got %h want %h", i, imem_addr, want[i]);
         end
      end
   endtask

   task automatic test_beqz();
      logic [63:0] want [6];
      clear_rom();
      rom[0] = enc(1, 0, 1, 0, 0, 32'd5);
      rom[1] = enc(0, 1, 2, 1, 1, 32'd0);
      rom[2] = enc(3, 0, 0, 2, 0, 32'hFFFF_FFFE);
      want   = '{64'h0, 64'h8, 64'h10, 64'h18, 64'h0, 64'h8};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_addr !== want[i]) begin
            n_bad++;
            $display("FAIL beqz_taken[%0d]: got %h want %h", i, imem_addr, want[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [63:0] want [8];
      logic        dv   [8];
      clear_rom();
      want = '{64'h0, 64'h8, 64'h10, 64'h10, 64'h10, 64'h10, 64'h18, 64'h20};
      dv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_addr !== want[i]) begin
            n_bad++;
            $display("FAIL stall[%0d]: got %h want %h", i, imem_addr, want[i]);
         end
         imem_data_valid = dv[i];
      end
      imem_data_valid = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [63:0] want [3];
      clear_rom();
      rom[0] = enc(1, 0, 1, 0, 0, 32'h48);
      do_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (imem_addr !== 64'd0 || imem_addr_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid: got %h/%b want 0/0", imem_addr, imem_addr_valid);
      end
      // R1 must not hold the in-flight ADDI result after reset
      rom[0] = enc(4, 0, 0, 1, 0, 32'h0);
      want   = '{64'h0, 64'h8, 64'h0};
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_addr !== want[i]) begin
            n_bad++;
            $display("FAIL reset_mid_resume[%0d]: got %h want %h", i, imem_addr, want[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] mpc;
      logic        pend_v;
      logic [63:0] pend_w;
      logic [63:0] pend_pc;
      logic        taken;
      logic [63:0] tgt;
      logic        dv;
      for (int round = 0; round < 6; round++) begin
         for (int i = 0; i < 64; i++) rom[i] = rand_insn();
         for (int i = 0; i < 64; i++) mregs[i] = 64'd0;
         mpc    = 64'd0;
         pend_v = 1'b0;
         pend_w = 64'd0;
         pend_pc = 64'd0;
         do_reset();
         for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_addr !== mpc || imem_addr_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL random r%0d c%0d: got %h/%b want %h/1", round, cyc, imem_addr,
                        imem_addr_valid, mpc);
            end
            dv = ($urandom_range(0, 9) < 8);
            imem_data_valid = dv;
            // Fetch at this cycle and execution of last cycle's fetch overlap
            taken = 1'b0;
            tgt   = 64'd0;
            if (pend_v) ref_exec(pend_w, pend_pc, taken, tgt);
            if (taken) begin
               mpc    = tgt;
               pend_v = 1'b0;
            end else if (dv) begin
               pend_v  = 1'b1;
               pend_w  = rom[mpc[8:3]];
               pend_pc = mpc;
               mpc     = mpc + 64'd8;
            end else begin
               pend_v = 1'b0;
            end
         end
      end
      imem_data_valid = 1'b1;
   endtask

   initial begin
      imem_data_valid = 1'b1;
      clear_rom();
      test_reset();
      test_nop_stream();
      test_jmp();
      test_bypass();
      test_beqz();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
